// File: rtl/soc_periph_arbiter_pkg.sv
// Shared SoC package: slave index map, address windows and arbiter FSM states.
// Pure declarations, no timing or flow control of its own.
// The decode-error states exist only when SOC_ARB_DECERR_EN is defined.
package soc_periph_arbiter_pkg;

  localparam int NB_PERIPHERALS = 5;

  typedef enum int unsigned {
    DRAM  = 0,
    UART  = 1,
    CLINT = 2,
    PERIP = 3,
    DEBUG = 4
  } axi_slaves_e;

  localparam logic [63:0] DEBUG_BASE   = 64'h0000_0000;
  localparam logic [63:0] DEBUG_LENGTH = 64'h0000_1000;
  localparam logic [63:0] CLINT_BASE   = 64'h0200_0000;
  localparam logic [63:0] CLINT_LENGTH = 64'h000C_0000;
  localparam logic [63:0] UART_BASE    = 64'h1000_0000;
  localparam logic [63:0] UART_LENGTH  = 64'h0000_1000;
  localparam logic [63:0] PERIP_BASE   = 64'h2000_0000;
  localparam logic [63:0] PERIP_LENGTH = 64'h6000_0000;
  localparam logic [63:0] DRAM_BASE    = 64'h8000_0000;
  localparam logic [63:0] DRAM_LENGTH  = 64'h4000_0000;

  // Indexed by axi_slaves_e (element 0 is DRAM)
  localparam logic [NB_PERIPHERALS-1:0][63:0] SLAVE_BASE =
    {DEBUG_BASE, PERIP_BASE, CLINT_BASE, UART_BASE, DRAM_BASE};
  localparam logic [NB_PERIPHERALS-1:0][63:0] SLAVE_LENGTH =
    {DEBUG_LENGTH, PERIP_LENGTH, CLINT_LENGTH, UART_LENGTH, DRAM_LENGTH};

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_REQ         = 3'd1,
    ST_RESP        = 3'd2
`ifdef SOC_ARB_DECERR_EN
    ,
    ST_DECERR      = 3'd3,
    ST_DECERR_RESP = 3'd4
`endif
  } arb_state_e;

endpackage

// File: rtl/soc_periph_arbiter_soc_addr_decode.sv
// Address decoder: maps a request address onto the one-hot slave window it hits.
// Purely combinational, zero latency.
// No flow control; miss_o flags an address outside every window.
module soc_addr_decode
  import soc_periph_arbiter_pkg::*;
#(
  parameter int AddrWidth = 64
) (
  input  logic [AddrWidth-1:0]      addr_i,
  output logic [NB_PERIPHERALS-1:0] slave_o,
  output logic                      miss_o
);

  // Compare at no less than 64 bits so base+length never wraps and upper address bits count
  localparam int CmpWidth = (AddrWidth > 64) ? AddrWidth : 64;

  logic [CmpWidth-1:0] addr_ext;

  assign addr_ext = CmpWidth'(addr_i);

  // Window check per slave: base inclusive, base+length exclusive
  always_comb begin
    slave_o = '0;
    for (int s = 0; s < NB_PERIPHERALS; s++) begin
      slave_o[s] = (addr_ext >= CmpWidth'(SLAVE_BASE[s])) &&
                   (addr_ext <  (CmpWidth'(SLAVE_BASE[s]) + CmpWidth'(SLAVE_LENGTH[s])));
    end
    miss_o = ~|slave_o;
  end

endmodule

// File: rtl/soc_periph_arbiter.sv
// Round-robin arbiter from NrMasters onto address-mapped slaves, one transaction outstanding.
// Latency: request to s_req_o 1 cycle; one IDLE cycle between back-to-back transactions.
// Masters hold m_req_i until m_gnt_o; slaves stall via s_gnt_i/s_rvalid_i. Miss handling set by SOC_ARB_DECERR_EN.
module soc_periph_arbiter
  import soc_periph_arbiter_pkg::*;
#(
  parameter int NrMasters = 2,
  parameter int NrSlaves  = 5,
  parameter int AddrWidth = 64,
  parameter int DataWidth = 64
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NrMasters-1:0]                  m_req_i,
  input  logic [NrMasters-1:0][AddrWidth-1:0]   m_addr_i,
  input  logic [NrMasters-1:0]                  m_we_i,
  input  logic [NrMasters-1:0][DataWidth/8-1:0] m_be_i,
  input  logic [NrMasters-1:0][DataWidth-1:0]   m_wdata_i,
  output logic [NrMasters-1:0]                  m_gnt_o,
  output logic [NrMasters-1:0]                  m_rvalid_o,
  output logic [NrMasters-1:0][DataWidth-1:0]   m_rdata_o,
  output logic [NrMasters-1:0]                  m_err_o,
  output logic [NrSlaves-1:0]                   s_req_o,
  output logic [AddrWidth-1:0]                  s_addr_o,
  output logic                                  s_we_o,
  output logic [DataWidth/8-1:0]                s_be_o,
  output logic [DataWidth-1:0]                  s_wdata_o,
  input  logic [NrSlaves-1:0]                   s_gnt_i,
  input  logic [NrSlaves-1:0]                   s_rvalid_i,
  input  logic [NrSlaves-1:0][DataWidth-1:0]    s_rdata_i,
  input  logic [NrSlaves-1:0]                   s_err_i
);

  localparam int IdxWidth = (NrMasters > 1) ? $clog2(NrMasters) : 1;
`ifndef SOC_ARB_DECERR_EN
  // Unmapped addresses fall through to DRAM
  localparam logic [NrSlaves-1:0] DramSel = NrSlaves'(1) << int'(DRAM);
`endif

  arb_state_e                  state_q;
  logic [IdxWidth-1:0]         rr_ptr_q;
  logic [IdxWidth-1:0]         winner_q;
  logic [NrSlaves-1:0]         slave_q;
  logic [AddrWidth-1:0]        addr_q;
  logic                        we_q;
  logic [DataWidth/8-1:0]      be_q;
  logic [DataWidth-1:0]        wdata_q;

  logic [IdxWidth-1:0]         cand;
  logic [IdxWidth-1:0]         arb_idx;
  logic                        arb_found;
  logic [IdxWidth-1:0]         next_ptr;
  logic [NB_PERIPHERALS-1:0]   dec_slave;
  logic                        dec_miss;
  logic                        sel_gnt;
  logic                        sel_rvalid;
  logic [DataWidth-1:0]        sel_rdata;
  logic                        sel_err;

  // Round-robin pick: first requester at or after the priority pointer
  always_comb begin
    arb_idx   = rr_ptr_q;
    arb_found = 1'b0;
    cand      = '0;
    for (int i = 0; i < NrMasters; i++) begin
      cand = IdxWidth'((int'(rr_ptr_q) + i) % NrMasters);
      if (!arb_found && m_req_i[cand]) begin
        arb_idx   = cand;
        arb_found = 1'b1;
      end
    end
  end

  assign next_ptr = (int'(arb_idx) == NrMasters - 1) ? '0 : arb_idx + 1'b1;

  soc_addr_decode #(
    .AddrWidth (AddrWidth)
  ) u_decode (
    .addr_i  (m_addr_i[arb_idx]),
    .slave_o (dec_slave),
    .miss_o  (dec_miss)
  );

  // Only the latched slave's handshakes and response are looked at
  always_comb begin
    sel_gnt    = |(s_gnt_i & slave_q);
    sel_rvalid = |(s_rvalid_i & slave_q);
    sel_rdata  = '0;
    sel_err    = 1'b0;
    for (int s = 0; s < NrSlaves; s++) begin
      if (slave_q[s]) begin
        sel_rdata = sel_rdata | s_rdata_i[s];
        sel_err   = sel_err | s_err_i[s];
      end
    end
  end

  // Outputs decoded from state; everything is zero in IDLE, hence during reset
  always_comb begin
    s_req_o    = '0;
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    m_rdata_o  = '0;
    m_err_o    = '0;
    case (state_q)
      ST_REQ: begin
        s_req_o = slave_q;
        if (sel_gnt) m_gnt_o[winner_q] = 1'b1;
      end
      ST_RESP: begin
        if (sel_rvalid) begin
          m_rvalid_o[winner_q] = 1'b1;
          m_rdata_o[winner_q]  = sel_rdata;
          m_err_o[winner_q]    = sel_err;
        end
      end
`ifdef SOC_ARB_DECERR_EN
      ST_DECERR:      m_gnt_o[winner_q] = 1'b1;
      ST_DECERR_RESP: begin
        m_rvalid_o[winner_q] = 1'b1;
        m_err_o[winner_q]    = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign s_addr_o  = addr_q;
  assign s_we_o    = we_q;
  assign s_be_o    = be_q;
  assign s_wdata_o = wdata_q;

  // FSM, round-robin pointer and latched winner payload
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      winner_q <= '0;
      slave_q  <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arb_found) begin
            winner_q <= arb_idx;
            rr_ptr_q <= next_ptr;
            addr_q   <= m_addr_i[arb_idx];
            we_q     <= m_we_i[arb_idx];
            be_q     <= m_be_i[arb_idx];
            wdata_q  <= m_wdata_i[arb_idx];
`ifdef SOC_ARB_DECERR_EN
            slave_q  <= dec_miss ? '0 : NrSlaves'(dec_slave);
            state_q  <= dec_miss ? ST_DECERR : ST_REQ;
`else
            slave_q  <= dec_miss ? DramSel : NrSlaves'(dec_slave);
            state_q  <= ST_REQ;
`endif
          end
        end
        ST_REQ:         if (sel_gnt) state_q <= ST_RESP;
        ST_RESP:        if (sel_rvalid) state_q <= ST_IDLE;
`ifdef SOC_ARB_DECERR_EN
        ST_DECERR:      state_q <= ST_DECERR_RESP;
        ST_DECERR_RESP: state_q <= ST_IDLE;
`endif
        default:        state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_periph_arbiter.sv
// Bench for soc_periph_arbiter: decode table, directed corner sequences, randomized traffic.
// The bench plays the slaves and checks grants, responses and routing against its own model.
// Miss expectations follow SOC_ARB_DECERR_EN when it is defined.
module tb_soc_periph_arbiter;
  import soc_periph_arbiter_pkg::*;

  localparam int NM = 2;
  localparam int NS = 5;
  localparam int AW = 64;
  localparam int DW = 64;
`ifdef SOC_ARB_DECERR_EN
  localparam bit DecErr = 1'b1;
`else
  localparam bit DecErr = 1'b0;
`endif

  // Address map as written in the SoC memory map, indexed DRAM, UART, CLINT, PERIP, Debug
  localparam longint unsigned RefBase [5] = '{64'h8000_0000, 64'h1000_0000, 64'h0200_0000,
                                              64'h2000_0000, 64'h0000_0000};
  localparam longint unsigned RefLen  [5] = '{64'h4000_0000, 64'h0000_1000, 64'h000C_0000,
                                              64'h6000_0000, 64'h0000_1000};

  logic                          clk = 1'b0;
  logic                          rst_n = 1'b0;
  logic [NM-1:0]                 m_req;
  logic [NM-1:0][AW-1:0]         m_addr;
  logic [NM-1:0]                 m_we;
  logic [NM-1:0][DW/8-1:0]       m_be;
  logic [NM-1:0][DW-1:0]         m_wdata;
  logic [NM-1:0]                 m_gnt;
  logic [NM-1:0]                 m_rvalid;
  logic [NM-1:0][DW-1:0]         m_rdata;
  logic [NM-1:0]                 m_err;
  logic [NS-1:0]                 s_req;
  logic [AW-1:0]                 s_addr;
  logic                          s_we;
  logic [DW/8-1:0]               s_be;
  logic [DW-1:0]                 s_wdata;
  logic [NS-1:0]                 s_gnt;
  logic [NS-1:0]                 s_rvalid;
  logic [NS-1:0][DW-1:0]         s_rdata;
  logic [NS-1:0]                 s_err;

  int n_checks = 0;
  int n_fail   = 0;
  int last_gnt;

  typedef struct {
    logic [63:0] addr;
    int          exp_slave;   // -1 = unmapped
  } dec_vec_t;

  dec_vec_t vecs [16];

  always #5 clk = ~clk;

  soc_periph_arbiter #(
    .NrMasters (NM),
    .NrSlaves  (NS),
    .AddrWidth (AW),
    .DataWidth (DW)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .m_req_i    (m_req),
    .m_addr_i   (m_addr),
    .m_we_i     (m_we),
    .m_be_i     (m_be),
    .m_wdata_i  (m_wdata),
    .m_gnt_o    (m_gnt),
    .m_rvalid_o (m_rvalid),
    .m_rdata_o  (m_rdata),
    .m_err_o    (m_err),
    .s_req_o    (s_req),
    .s_addr_o   (s_addr),
    .s_we_o     (s_we),
    .s_be_o     (s_be),
    .s_wdata_o  (s_wdata),
    .s_gnt_i    (s_gnt),
    .s_rvalid_i (s_rvalid),
    .s_rdata_i  (s_rdata),
    .s_err_i    (s_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decode straight from the memory map: offset from base must be below length
  function automatic int ref_decode(input logic [63:0] a);
    for (int s = 0; s < 5; s++) begin
      if (a >= RefBase[s] && (a - RefBase[s]) < RefLen[s]) return s;
    end
    return -1;
  endfunction

  // Expected s_req_o for a decoded slave (misses go to DRAM unless decode errors are enabled)
  function automatic logic [NS-1:0] exp_sel(input int s);
    if (s >= 0) return NS'(1) << s;
    return DecErr ? '0 : NS'(1);
  endfunction

  // Round robin: first requester counting up from the one after the last grant
  function automatic int ref_winner(input logic [NM-1:0] mask, input int last);
    for (int k = 1; k <= NM; k++) begin
      if (mask[(last + k) % NM]) return (last + k) % NM;
    end
    return -1;
  endfunction

  function automatic logic [63:0] rand_addr();
    int r;
    r = $urandom_range(0, 4);
    case ($urandom_range(0, 4))
      0:       return {32'h0, $urandom};
      1:       return RefBase[r] + RefLen[r] - 1;
      2:       return RefBase[r] + RefLen[r];
      3:       return RefBase[r] + (longint'($urandom) % RefLen[r]);
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // One transaction for master m, entered at posedge+1 with m's request already driven.
  // The bench acts as the slave; gdel/rdel (>=1) are cycles of s_req_o / RESP before handshake.
  task automatic txn(input int m, input int exp_s, input bit keep, input int gdel, input int rdel,
                     input logic [DW-1:0] rd, input bit er);
    logic [NS-1:0] sel;
    int            sidx;
    bit            miss_dec;
    bit            seen;
    int            n;
    sel      = exp_sel(exp_s);
    sidx     = (exp_s < 0) ? 0 : exp_s;
    miss_dec = DecErr && (exp_s < 0);
    seen     = 1'b0;
    n        = 0;
    while (!seen && n < 8) begin
      @(negedge clk);
      seen = miss_dec ? (m_gnt != '0) : (s_req != '0);
      if (!seen) begin
        chk("no_gnt_before_req", 64'(m_gnt), 64'(0));
        @(posedge clk); #1;
        n++;
      end
    end
    chk("txn_started", 64'(seen), 64'(1));
    if (!seen) return;
    chk("req_latency", 64'(n), 64'(1));
    if (miss_dec) begin
      chk("decerr_gnt", 64'(m_gnt), 64'(1) << m);
      chk("decerr_no_sreq", 64'(s_req), 64'(0));
      @(posedge clk); #1;
      if (!keep) m_req[m] = 1'b0;
      @(negedge clk);
      chk("decerr_rvalid", 64'(m_rvalid), 64'(1) << m);
      chk("decerr_err", 64'(m_err), 64'(1) << m);
      chk("decerr_rdata", m_rdata[m], 64'(0));
      chk("decerr_no_sreq2", 64'(s_req), 64'(0));
      chk("decerr_single_gnt", 64'(m_gnt), 64'(0));
      @(posedge clk); #1;
      return;
    end
    chk("s_req_sel", 64'(s_req), 64'(sel));
    chk("s_addr", s_addr, m_addr[m]);
    chk("s_we", 64'(s_we), 64'(m_we[m]));
    chk("s_be", 64'(s_be), 64'(m_be[m]));
    chk("s_wdata", s_wdata, m_wdata[m]);
    for (int i = 1; i < gdel; i++) begin
      @(posedge clk); #1;
      s_gnt    = NS'($urandom) & ~sel;
      s_rvalid = NS'($urandom);
      @(negedge clk);
      chk("foreign_gnt_ignored", 64'(m_gnt), 64'(0));
      chk("rvalid_in_req_ignored", 64'(m_rvalid), 64'(0));
      chk("s_req_hold", 64'(s_req), 64'(sel));
    end
    @(posedge clk); #1;
    s_gnt    = sel | (NS'($urandom) & ~sel);
    s_rvalid = '0;
    @(negedge clk);
    chk("m_gnt", 64'(m_gnt), 64'(1) << m);
    @(posedge clk); #1;
    if (!keep) m_req[m] = 1'b0;
    s_gnt = '0;
    for (int i = 1; i < rdel; i++) begin
      s_rvalid = NS'($urandom) & ~sel;
      s_gnt    = NS'($urandom);
      @(negedge clk);
      chk("rvalid_wait", 64'(m_rvalid), 64'(0));
      chk("gnt_in_resp_ignored", 64'(m_gnt), 64'(0));
      chk("s_req_off_in_resp", 64'(s_req), 64'(0));
      for (int k = 0; k < NM; k++) chk("rdata_zero_idle", m_rdata[k], 64'(0));
      @(posedge clk); #1;
    end
    for (int s = 0; s < NS; s++) begin
      s_rdata[s] = {$urandom, $urandom};
      s_err[s]   = 1'($urandom);
    end
    s_rdata[sidx] = rd;
    s_err[sidx]   = er;
    s_rvalid      = sel | (NS'($urandom) & ~sel);
    s_gnt         = '0;
    @(negedge clk);
    chk("m_rvalid", 64'(m_rvalid), 64'(1) << m);
    chk("m_rdata", m_rdata[m], rd);
    chk("m_err", 64'(m_err), 64'(er) << m);
    chk("other_rdata_zero", m_rdata[1 - m], 64'(0));
    @(posedge clk); #1;
    s_rvalid = '0;
    s_gnt    = '0;
  endtask

  initial begin
    #2_000_000;
    $fatal(1, "FAIL watchdog: simulation did not finish in time");
  end

  initial begin
    vecs[0]  = '{64'h0000_0FFF, 4};
    vecs[1]  = '{64'h0000_1000, -1};
    vecs[2]  = '{64'h7FFF_FFFF, 3};
    vecs[3]  = '{64'hC000_0000, -1};
    vecs[4]  = '{64'h0000_0000, 4};
    vecs[5]  = '{64'h0200_0000, 2};
    vecs[6]  = '{64'h020B_FFFF, 2};
    vecs[7]  = '{64'h020C_0000, -1};
    vecs[8]  = '{64'h1000_0004, 1};
    vecs[9]  = '{64'h1000_1000, -1};
    vecs[10] = '{64'h2000_0000, 3};
    vecs[11] = '{64'h8000_0000, 0};
    vecs[12] = '{64'hBFFF_FFFF, 0};
    vecs[13] = '{64'h1_8000_0000, -1};
    vecs[14] = '{64'h0000_2000, -1};
    vecs[15] = '{64'h0FFF_FFFF, -1};

    m_req = '0; m_addr = '0; m_we = '0; m_be = '0; m_wdata = '0;
    s_gnt = '0; s_rvalid = '0; s_rdata = '0; s_err = '0;

    // Reset state
    @(negedge clk);
    chk("rst_s_req", 64'(s_req), 64'(0));
    chk("rst_m_gnt", 64'(m_gnt), 64'(0));
    chk("rst_m_rvalid", 64'(m_rvalid), 64'(0));
    chk("rst_m_err", 64'(m_err), 64'(0));
    chk("rst_s_addr", s_addr, 64'(0));
    chk("rst_s_we", 64'(s_we), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Master 0 reads UART: grant in cycle 2, response 0xAB in cycle 4
    m_addr[0] = 64'h1000_0004; m_we[0] = 1'b0; m_be[0] = 8'hFF; m_wdata[0] = '0;
    m_req[0]  = 1'b1;
    txn(0, 1, 1'b0, 1, 2, 64'hAB, 1'b0);
    last_gnt = 0;

    // Master 1 writes an unmapped address
    m_addr[1] = 64'h0000_2000; m_we[1] = 1'b1; m_be[1] = 8'h0F; m_wdata[1] = 64'h1234_5678;
    m_req[1]  = 1'b1;
    txn(1, -1, 1'b0, 1, 1, 64'h55, 1'b1);
    last_gnt = 1;

    // Both masters hammer DRAM: grants alternate 0,1,0,1
    m_addr[0] = 64'h8000_0000; m_addr[1] = 64'h8000_0000;
    m_we = '0;
    m_req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      txn(k % 2, 0, 1'b1, 1 + (k % 2), 1, {$urandom, $urandom}, 1'b0);
    end
    m_req = '0;
    last_gnt = 1;

    // Decode table through master 0
    for (int v = 0; v < 16; v++) begin
      m_addr[0]  = vecs[v].addr;
      m_we[0]    = 1'($urandom);
      m_be[0]    = 8'($urandom);
      m_wdata[0] = {$urandom, $urandom};
      m_req[0]   = 1'b1;
      txn(0, vecs[v].exp_slave, 1'b0, $urandom_range(1, 3), $urandom_range(1, 3),
          {$urandom, $urandom}, 1'($urandom));
    end
    last_gnt = 0;

    // Reset during RESP: late response dropped, priority back to master 0
    m_addr[0] = 64'h1000_0004; m_we[0] = 1'b0;
    m_req[0]  = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_seq_s_req", 64'(s_req), 64'(5'b00010));
    @(posedge clk); #1;
    s_gnt = 5'b00010;
    @(negedge clk);
    chk("rst_seq_gnt", 64'(m_gnt), 64'(1));
    @(posedge clk); #1;
    m_req[0] = 1'b0;
    s_gnt    = '0;
    @(negedge clk);
    chk("rst_seq_resp_wait", 64'(m_rvalid), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_s_req", 64'(s_req), 64'(0));
    chk("midrst_m_gnt", 64'(m_gnt), 64'(0));
    chk("midrst_m_rvalid", 64'(m_rvalid), 64'(0));
    chk("midrst_s_addr", s_addr, 64'(0));
    @(posedge clk); #1;
    rst_n      = 1'b1;
    s_rvalid   = 5'b00010;
    s_rdata[1] = 64'hDEAD_BEEF;
    @(negedge clk);
    chk("late_rvalid_dropped", 64'(m_rvalid), 64'(0));
    chk("late_rdata_zero", m_rdata[0], 64'(0));
    chk("idle_after_rst", 64'(s_req), 64'(0));
    @(posedge clk); #1;
    s_rvalid = '0;
    m_addr[1] = 64'h1000_0008;
    m_req = 2'b11;
    txn(0, 1, 1'b0, 1, 1, 64'h77, 1'b0);
    txn(1, 1, 1'b0, 1, 1, 64'h88, 1'b1);
    last_gnt = 1;

    // Randomized traffic against the reference model
    for (int it = 0; it < 40; it++) begin
      logic [NM-1:0] rem;
      int            w;
      rem = NM'($urandom_range(1, 3));
      for (int k = 0; k < NM; k++) begin
        if (rem[k]) begin
          m_addr[k]  = rand_addr();
          m_we[k]    = 1'($urandom);
          m_be[k]    = 8'($urandom);
          m_wdata[k] = {$urandom, $urandom};
          m_req[k]   = 1'b1;
        end
      end
      while (rem != '0) begin
        w = ref_winner(rem, last_gnt);
        txn(w, ref_decode(m_addr[w]), 1'b0, $urandom_range(1, 3), $urandom_range(1, 3),
            {$urandom, $urandom}, 1'($urandom));
        last_gnt = w;
        rem[w]   = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
